grf: RTL and testbench
======================

GRF -- requirements
Module: grf

Interface
REQ-001 The block SHALL take parameter LOG_DEPTH, default 4: the number of write-log FIFO entries, a power of two, 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port WD_RegWrite, input, 1 bit: write enable from the writeback stage.
REQ-005 The block SHALL have port WD_WRA, input, 5 bits: write register address.
REQ-006 The block SHALL have port WD_WRD, input, 32 bits: write data.
REQ-007 The block SHALL have port WD_PCWhenWrite, input, 32 bits: PC of the instruction performing the write.
REQ-008 The block SHALL have ports D_RA1 and D_RA2, input, 5 bits each: decode-stage read addresses.
REQ-009 The block SHALL have ports D_RD1 and D_RD2, output, 32 bits each: read data.
REQ-010 The block SHALL have port log_valid, output, 1 bit: the log FIFO head is valid.
REQ-011 The block SHALL have port log_ready, input, 1 bit: the monitor accepts the log FIFO head.
REQ-012 The block SHALL have ports log_pc, log_addr and log_data, output, 32, 5 and 32 bits: the head entry.
REQ-013 The block SHALL have port log_overflow, output, 1 bit: sticky flag, set when a log entry was dropped.
REQ-014 The block SHALL have port log_count, output, $clog2(LOG_DEPTH)+1 bits: FIFO occupancy.

Function
REQ-015 The block SHALL hold 32 registers of 32 bits; register 0 always reads 0, and writes to it are discarded.
REQ-016 The block SHALL commit a write on the rising clk edge when WD_RegWrite=1 and WD_WRA!=0: reg[WD_WRA] <= WD_WRD.
REQ-017 The block SHALL make reads combinational, with a same-cycle bypass: if WD_RegWrite=1, WD_WRA!=0 and WD_WRA==D_RAx, then D_RDx = WD_WRD; otherwise D_RDx = reg[D_RAx].
REQ-018 The block SHALL push {WD_PCWhenWrite, WD_WRA, WD_WRD} into the log FIFO on every committed write.
  - Writes to register 0 SHALL NOT be logged.
REQ-019 The block SHALL pop the FIFO head on a clk edge where log_valid=1 and log_ready=1.
  - log_valid SHALL equal (log_count != 0).
  - The head outputs SHALL be stable while log_valid=1 and log_ready=0.
REQ-020 The block SHALL allow a push and a pop in the same cycle at any occupancy, including full.
  - In that cycle, occupancy SHALL stay unchanged and the entry SHALL be accepted.
REQ-021 The block SHALL handle a push while the FIFO is full with no pop in the same cycle as follows.
  - The register write SHALL still commit.
  - The log entry SHALL be dropped.
  - log_overflow SHALL become 1 and hold until reset.
REQ-022 The block SHALL use FIFO pointers LOG_DEPTH deep that wrap modulo LOG_DEPTH; log_count SHALL range 0..LOG_DEPTH.
REQ-023 The block SHALL ignore a pop while empty, and log_valid SHALL then be 0.
REQ-024 The block SHALL output head fields of 0 while the FIFO is empty.

Reset
REQ-025 The block SHALL, while reset_n=0, asynchronously clear all 32 registers, the FIFO pointers and the count to 0, and clear log_overflow.
REQ-026 The block SHALL drive log_valid=0, log_count=0 and D_RDx=0 (bypass inactive) while reset_n=0, and SHALL ignore any write or pop presented during reset.
REQ-027 The block SHALL resume normal operation on the first rising clk edge after reset_n deasserts; a reset mid-drain SHALL discard all pending log entries.

Structure
REQ-028 The block SHALL take the register-address width (5), data width (32) and the zero-register index from the shared macro header.
REQ-029 The block SHALL implement the log as one sub-module, grf_log_fifo, parameterised by depth and entry width (69 bits); the register array and bypass SHALL remain in grf.

Verification
REQ-030 The bench SHALL write reg5=0xDEADBEEF (PC 0x3000), then read RA1=5 the next cycle, and SHALL see D_RD1=0xDEADBEEF; log holds one entry {0x3000, 5, 0xDEADBEEF}.
REQ-031 The bench SHALL write reg0=0x1234 and read RA2=0, and SHALL see D_RD2=0; log_count stays 0.
REQ-032 The bench SHALL, in the same cycle, write reg8=0xA5A5A5A5 with RA1=8 while reg8 holds 0x11, and SHALL see D_RD1=0xA5A5A5A5 that cycle.
REQ-033 The bench SHALL, with LOG_DEPTH=4 and log_ready=0, perform 5 writes and SHALL see log_count=4 and log_overflow=1; draining SHALL return the first 4 entries in order and all 5 registers SHALL hold the written data.
REQ-034 The bench SHALL, with the FIFO full and log_ready=1, perform a write and SHALL see log_count stay 4, log_overflow stay 0, and the new entry appear after 3 further pops.
REQ-035 The bench SHALL, after 3 logged writes to reg1..reg3, assert reset_n=0 between clk edges and SHALL see log_valid=0 and all registers read 0 immediately.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared widths, zero-register index and log entry layout for the general register file.
package grf_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned PC_W     = 32;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;
  localparam int unsigned ZERO_REG = 0;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } log_entry_t;

  localparam int unsigned LOG_W = $bits(log_entry_t);

  function automatic log_entry_t make_entry(input logic [PC_W-1:0]   pc,
                                            input logic [ADDR_W-1:0] addr,
                                            input logic [DATA_W-1:0] data);
    log_entry_t e;
    e.pc   = pc;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/grf_log_fifo.sv
// Write-log FIFO: push/pop in the same cycle always succeeds; a push into a full FIFO
// without a pop is dropped and latches a sticky overflow flag.
module grf_log_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 69
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     valid,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic             full;
  logic             do_push;
  logic             do_pop;
  logic             drop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  // Storage needs no reset: entries are only visible through the count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_q <= count_q - CNT_W'(1);
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign valid    = (count_q != '0);
  assign head     = valid ? mem[rd_ptr] : '0;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/grf.sv
// 32x32 general register file with same-cycle write bypass and a write-log FIFO
// that records every committed write for an external monitor.
module grf
  import grf_pkg::*;
#(
  parameter int unsigned LOG_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      WD_RegWrite,
  input  logic [ADDR_W-1:0]         WD_WRA,
  input  logic [DATA_W-1:0]         WD_WRD,
  input  logic [PC_W-1:0]           WD_PCWhenWrite,
  input  logic [ADDR_W-1:0]         D_RA1,
  input  logic [ADDR_W-1:0]         D_RA2,
  output logic [DATA_W-1:0]         D_RD1,
  output logic [DATA_W-1:0]         D_RD2,
  output logic                      log_valid,
  input  logic                      log_ready,
  output logic [PC_W-1:0]           log_pc,
  output logic [ADDR_W-1:0]         log_addr,
  output logic [DATA_W-1:0]         log_data,
  output logic                      log_overflow,
  output logic [$clog2(LOG_DEPTH):0] log_count
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_commit;
  logic              bypass_en;
  log_entry_t        push_e;
  log_entry_t        head_e;

  assign wr_commit = WD_RegWrite && (WD_WRA != ADDR_W'(ZERO_REG));
  // Bypass is suppressed during reset so reads see the cleared array.
  assign bypass_en = wr_commit && reset_n;

  // Register 0 is reset and never written, so it always reads zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_commit) begin
      regs[WD_WRA] <= WD_WRD;
    end
  end

  always_comb begin
    D_RD1 = regs[D_RA1];
    D_RD2 = regs[D_RA2];
    if (bypass_en && (WD_WRA == D_RA1)) D_RD1 = WD_WRD;
    if (bypass_en && (WD_WRA == D_RA2)) D_RD2 = WD_WRD;
  end

  assign push_e = make_entry(WD_PCWhenWrite, WD_WRA, WD_WRD);

  grf_log_fifo #(
    .DEPTH (LOG_DEPTH),
    .WIDTH (LOG_W)
  ) u_log_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (wr_commit),
    .push_data (push_e),
    .pop       (log_ready),
    .valid     (log_valid),
    .head      (head_e),
    .count     (log_count),
    .overflow  (log_overflow)
  );

  assign log_pc   = head_e.pc;
  assign log_addr = head_e.addr;
  assign log_data = head_e.data;

endmodule

// File: tb/tb_grf.sv
// Self-checking bench for grf: directed vector table, hand sequences for FIFO full/overflow
// and mid-drain reset, and randomized traffic against a queue-based reference model.
module tb_grf;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset_n;
  logic        WD_RegWrite;
  logic [4:0]  WD_WRA;
  logic [31:0] WD_WRD;
  logic [31:0] WD_PCWhenWrite;
  logic [4:0]  D_RA1, D_RA2;
  logic [31:0] D_RD1, D_RD2;
  logic        log_valid;
  logic        log_ready;
  logic [31:0] log_pc;
  logic [4:0]  log_addr;
  logic [31:0] log_data;
  logic        log_overflow;
  logic [2:0]  log_count;

  grf #(.LOG_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .WD_RegWrite    (WD_RegWrite),
    .WD_WRA         (WD_WRA),
    .WD_WRD         (WD_WRD),
    .WD_PCWhenWrite (WD_PCWhenWrite),
    .D_RA1          (D_RA1),
    .D_RA2          (D_RA2),
    .D_RD1          (D_RD1),
    .D_RD2          (D_RD2),
    .log_valid      (log_valid),
    .log_ready      (log_ready),
    .log_pc         (log_pc),
    .log_addr       (log_addr),
    .log_data       (log_data),
    .log_overflow   (log_overflow),
    .log_count      (log_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model: plain array of registers plus a queue of logged writes.
  typedef struct {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  logic [31:0] m_regs [32];
  ent_t        m_q [$];
  bit          m_ovf;

  typedef struct {
    bit          wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    bit          rdy;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    int          e_cnt;
    logic [31:0] e_pc;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit wr, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [31:0] pc, input logic [4:0] ra1, input logic [4:0] ra2,
                       input bit rdy);
    WD_RegWrite    = wr;
    WD_WRA         = wa;
    WD_WRD         = wd;
    WD_PCWhenWrite = pc;
    D_RA1          = ra1;
    D_RA2          = ra2;
    log_ready      = rdy;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_q.delete();
    m_ovf = 1'b0;
  endtask

  // Advance one clock and apply the same edge to the model.
  task automatic step();
    bit   pop;
    ent_t e;
    @(posedge clk);
    if (reset_n) begin
      pop = log_ready && (m_q.size() > 0);
      if (pop) void'(m_q.pop_front());
      if (WD_RegWrite && (WD_WRA != 5'd0)) begin
        m_regs[WD_WRA] = WD_WRD;
        if (m_q.size() < int'(DEPTH)) begin
          e.pc = WD_PCWhenWrite; e.addr = WD_WRA; e.data = WD_WRD;
          m_q.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic check_model();
    logic [31:0] e_rd1, e_rd2;
    bit          byp;
    ent_t        h;
    byp   = WD_RegWrite && (WD_WRA != 5'd0) && reset_n;
    e_rd1 = (byp && WD_WRA == D_RA1) ? WD_WRD : m_regs[D_RA1];
    e_rd2 = (byp && WD_WRA == D_RA2) ? WD_WRD : m_regs[D_RA2];
    if (m_q.size() > 0) h = m_q[0];
    else begin h.pc = 32'h0; h.addr = 5'd0; h.data = 32'h0; end
    check("rnd_rd1", D_RD1, e_rd1);
    check("rnd_rd2", D_RD2, e_rd2);
    check("rnd_valid", 32'(log_valid), 32'(m_q.size() != 0));
    check("rnd_count", 32'(log_count), 32'(m_q.size()));
    check("rnd_pc", log_pc, h.pc);
    check("rnd_addr", 32'(log_addr), 32'(h.addr));
    check("rnd_data", log_data, h.data);
    check("rnd_ovf", 32'(log_overflow), 32'(m_ovf));
  endtask

  task automatic do_reset();
    drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(log_valid), 32'h0);
    check("rst_count", 32'(log_count), 32'h0);
    check("rst_ovf", 32'(log_overflow), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    model_reset();
    #2;
    check("rst_rd1", D_RD1, 32'h0);
    do_reset();

    // Directed vectors: write/read-back, reg0 discard, bypass, drain, pop on empty.
    vt[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 32'h3000, 5'd5, 5'd0, 1'b0,
              32'hDEADBEEF, 32'h0, 0, 32'h0, 5'd0, 32'h0};
    vt[1] = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd5, 1'b0,
              32'hDEADBEEF, 32'hDEADBEEF, 1, 32'h3000, 5'd5, 32'hDEADBEEF};
    vt[2] = '{1'b1, 5'd0, 32'h1234, 32'h3004, 5'd0, 5'd0, 1'b0,
              32'h0, 32'h0, 1, 32'h3000, 5'd5, 32'hDEADBEEF};
    vt[3] = '{1'b1, 5'd8, 32'h11, 32'h3008, 5'd5, 5'd0, 1'b0,
              32'hDEADBEEF, 32'h0, 1, 32'h3000, 5'd5, 32'hDEADBEEF};
    vt[4] = '{1'b1, 5'd8, 32'hA5A5A5A5, 32'h300C, 5'd8, 5'd3, 1'b0,
              32'hA5A5A5A5, 32'h0, 2, 32'h3000, 5'd5, 32'hDEADBEEF};
    vt[5] = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd8, 5'd5, 1'b1,
              32'hA5A5A5A5, 32'hDEADBEEF, 3, 32'h3000, 5'd5, 32'hDEADBEEF};
    vt[6] = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1,
              32'h0, 32'h0, 2, 32'h3008, 5'd8, 32'h11};
    vt[7] = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1,
              32'h0, 32'h0, 1, 32'h300C, 5'd8, 32'hA5A5A5A5};
    vt[8] = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1,
              32'h0, 32'h0, 0, 32'h0, 5'd0, 32'h0};
    vt[9] = '{1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1,
              32'h0, 32'h0, 0, 32'h0, 5'd0, 32'h0};

    for (int v = 0; v < 10; v++) begin
      drive(vt[v].wr, vt[v].wa, vt[v].wd, vt[v].pc, vt[v].ra1, vt[v].ra2, vt[v].rdy);
      @(negedge clk);
      check($sformatf("vec%0d_rd1", v), D_RD1, vt[v].e_rd1);
      check($sformatf("vec%0d_rd2", v), D_RD2, vt[v].e_rd2);
      check($sformatf("vec%0d_count", v), 32'(log_count), 32'(vt[v].e_cnt));
      check($sformatf("vec%0d_valid", v), 32'(log_valid), 32'(vt[v].e_cnt != 0));
      check($sformatf("vec%0d_pc", v), log_pc, vt[v].e_pc);
      check($sformatf("vec%0d_addr", v), 32'(log_addr), 32'(vt[v].e_addr));
      check($sformatf("vec%0d_data", v), log_data, vt[v].e_data);
      check($sformatf("vec%0d_ovf", v), 32'(log_overflow), 32'h0);
      step();
    end

    // Five writes into a 4-deep log with the monitor stalled.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'(10 + i), 32'hC0DE0000 + 32'(i), 32'h4000 + 32'(4 * i), 5'd0, 5'd0, 1'b0);
      step();
    end
    drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    #1;
    check("ovf_count", 32'(log_count), 32'd4);
    check("ovf_flag", 32'(log_overflow), 32'h1);
    #2;
    check("ovf_head_stable", 32'(log_addr), 32'd10);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1);
      #1;
      check($sformatf("drain%0d_pc", i), log_pc, 32'h4000 + 32'(4 * i));
      check($sformatf("drain%0d_addr", i), 32'(log_addr), 32'(10 + i));
      check($sformatf("drain%0d_data", i), log_data, 32'hC0DE0000 + 32'(i));
      step();
    end
    check("drain_empty_valid", 32'(log_valid), 32'h0);
    check("drain_empty_ovf", 32'(log_overflow), 32'h1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 5'd0, 32'h0, 32'h0, 5'(10 + i), 5'd0, 1'b0);
      #1;
      check($sformatf("ovf_reg%0d", 10 + i), D_RD1, 32'hC0DE0000 + 32'(i));
    end
    step();

    // Push and pop together while full.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(20 + i), 32'h100 + 32'(i), 32'h5000 + 32'(4 * i), 5'd0, 5'd0, 1'b0);
      step();
    end
    check("full_count", 32'(log_count), 32'd4);
    drive(1'b1, 5'd24, 32'hFEED, 32'h5010, 5'd0, 5'd0, 1'b1);
    step();
    check("pp_count", 32'(log_count), 32'd4);
    check("pp_ovf", 32'(log_overflow), 32'h0);
    check("pp_head", 32'(log_addr), 32'd21);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1);
      step();
    end
    drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    #1;
    check("pp_new_pc", log_pc, 32'h5010);
    check("pp_new_addr", 32'(log_addr), 32'd24);
    check("pp_new_data", log_data, 32'hFEED);
    check("pp_new_count", 32'(log_count), 32'd1);

    // Reset asserted between edges with entries pending.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 5'(i), 32'h70 + 32'(i), 32'h6000 + 32'(i), 5'd0, 5'd0, 1'b0);
      step();
    end
    drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd1, 5'd2, 1'b0);
    #1;
    check("pre_rst_rd1", D_RD1, 32'h71);
    check("pre_rst_count", 32'(log_count), 32'd3);
    #2;
    reset_n = 1'b0;
    drive(1'b1, 5'd3, 32'h999, 32'h6100, 5'd3, 5'd2, 1'b1);
    #1;
    check("mid_rst_valid", 32'(log_valid), 32'h0);
    check("mid_rst_count", 32'(log_count), 32'h0);
    check("mid_rst_rd1", D_RD1, 32'h0);
    check("mid_rst_rd2", D_RD2, 32'h0);
    @(posedge clk);
    #1;
    check("rst_edge_rd1", D_RD1, 32'h0);
    check("rst_edge_count", 32'(log_count), 32'h0);
    drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd1, 1'b1);
    reset_n = 1'b1;
    model_reset();
    step();
    check("post_rst_rd1", D_RD1, 32'h0);
    check("post_rst_rd2", D_RD2, 32'h0);
    check("post_rst_valid", 32'(log_valid), 32'h0);

    // Randomized traffic with alternating stalled/draining monitor phases.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [4:0] wa;
      bit         wr, rdy;
      wr  = ($urandom_range(0, 9) < 7);
      wa  = 5'($urandom_range(0, 31));
      rdy = ((c / 40) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      drive(wr, wa, $urandom(), $urandom(),
            ($urandom_range(0, 1) == 1) ? wa : 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), rdy);
      @(negedge clk);
      check_model();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
